// File: rtl/syn_fifo.sv
// Synchronous single-clock FIFO with registered read data and any depth >= 2.
// Status flags are decoded from the registered occupancy count only.
module syn_fifo #(
  parameter int DEP = 4,
  parameter int WID = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wr_i,
  input  logic           rd_i,
  input  logic [WID-1:0] wdata,
  output logic [WID-1:0] rdata,
  output logic           overflow_o,
  empty_o
);

  localparam int PW = (DEP > 1) ? $clog2(DEP) : 1;
  localparam int CW = $clog2(DEP + 1);

  localparam logic [PW-1:0] PTR_LAST = PW'(DEP - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEP);

  logic [WID-1:0] mem_q [DEP];
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [CW-1:0]  cnt_q,  cnt_d;
  logic [WID-1:0] rdata_q, rdata_d;

  logic full, empty;
  logic rd_acc, wr_acc;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  assign rd_acc = rd_i && !empty;
  assign wr_acc = wr_i && (!full || rd_acc);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    if (wr_acc) wptr_d = ptr_inc(wptr_q);

    if (rd_acc) begin
      rptr_d  = ptr_inc(rptr_q);
      rdata_d = mem_q[rptr_q];
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: storage is deliberately not reset; cleared pointers and count keep stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr_q] <= wdata;
  end

  assign rdata      = rdata_q;
  assign overflow_o = full;
  assign empty_o    = empty;

endmodule

// File: tb/tb_syn_fifo.sv
// Self-checking bench for syn_fifo: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_syn_fifo;

  localparam int DEP = 4;
  localparam int WID = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_i, rd_i;
  logic [WID-1:0] wdata;
  logic [WID-1:0] rdata;
  logic           overflow_o, empty_o;

  int total = 0;
  int bad   = 0;

  logic [WID-1:0] m_q[$];
  logic [WID-1:0] m_rdata;
  bit             cmp_en = 1'b0;

  syn_fifo #(.DEP(DEP), .WID(WID)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_i       (wr_i),
    .rd_i       (rd_i),
    .wdata      (wdata),
    .rdata      (rdata),
    .overflow_o (overflow_o),
    .empty_o    (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rdata = '0;
  endtask

  // One clock: apply request, wait for the edge, advance the model, settle 1 time unit.
  task automatic step(input logic w, input logic r, input logic [WID-1:0] d);
    bit rd_ok, wr_ok;
    wr_i  = w;
    rd_i  = r;
    wdata = d;
    @(posedge clk);
    if (rst) begin
      rd_ok = r && (m_q.size() > 0);
      wr_ok = w && ((m_q.size() < DEP) || rd_ok);
      if (rd_ok) m_rdata = m_q.pop_front();
      if (wr_ok) m_q.push_back(d);
    end
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges; flags must react at once.
  task automatic async_reset(input int hold_cycles);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("rst_empty_now", empty_o, 1'b1);
    check("rst_ovf_now", overflow_o, 1'b0);
    check("rst_rdata_now", rdata, '0);
    for (int i = 0; i < hold_cycles; i++) step(i[0], ~i[0], 8'hEE);
    rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("rdata", rdata, m_rdata);
      check("empty", empty_o, m_q.size() == 0);
      check("overflow", overflow_o, m_q.size() == DEP);
    end
  end

  initial begin
    rst   = 1'b0;
    wr_i  = 1'b0;
    rd_i  = 1'b0;
    wdata = '0;
    model_reset();
    cmp_en = 1'b1;

    // Reset held with requests toggling: outputs stay at reset values.
    for (int i = 0; i < 6; i++) begin
      step(i[0], i[1], 8'hA0 + 8'(i));
      check("hold_rst_empty", empty_o, 1'b1);
      check("hold_rst_rdata", rdata, '0);
    end
    rst = 1'b1;

    // Concurrent read+write from empty: first read ignored, then one-deep pass-through.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 8'h10 + 8'(i));
      if (i == 0) begin
        check("conc_first_empty", empty_o, 1'b0);
        check("conc_first_rdata", rdata, 8'h00);
      end
    end
    check("conc_last_rdata", rdata, 8'h18);
    check("conc_ovf", overflow_o, 1'b0);

    // Fill: only three of ten writes fit, the rest are dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'h20 + 8'(i));
    check("fill_ovf", overflow_o, 1'b1);

    // Drain: 19, 20, 21, 22 in order, then rdata holds.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 8'h00);
      if (i == 0) check("drain_first", rdata, 8'h19);
      if (i == 3) check("drain_4th_empty", empty_o, 1'b1);
    end
    check("drain_hold", rdata, 8'h22);

    // Wrap: six writes, reading alongside from the fourth on, then drain.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, i >= 3, 8'h30 + 8'(i));
      if (i == 3) check("wrap_rd0", rdata, 8'h30);
    end
    check("wrap_rd2", rdata, 8'h32);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);
    check("wrap_last", rdata, 8'h35);
    check("wrap_empty", empty_o, 1'b1);

    // Mid-operation reset with three entries stored.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    async_reset(2);
    step(1'b1, 1'b1, 8'h55);
    check("post_rst_rd_ignored", rdata, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    check("post_rst_new_data", rdata, 8'h55);
    check("post_rst_empty", empty_o, 1'b1);

    // Randomized traffic with shifting read/write bias and occasional resets.
    for (int blk = 0; blk < 20; blk++) begin
      int wp, rp;
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 150; i++)
        step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
      if (blk % 7 == 6) async_reset($urandom_range(0, 2));
    end

    step(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/syn_fifo.md
SYN_FIFO -- requirements
Module: syn_fifo

Interface
REQ-001 Parameter DEP, default 4, number of storage entries (SHALL support DEP >= 2, any integer, not only powers of two).
REQ-002 Parameter WID, default 8, data width in bits; parameter order SHALL be DEP then WID.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 wr_i  input  1  write request.
REQ-006 rd_i  input  1  read request.
REQ-007 wdata  input  WID  write data, sampled on an accepted write.
REQ-008 rdata  output  WID  read data, registered.
REQ-009 overflow_o  output  1  full indicator; high when occupancy == DEP.
REQ-010 empty_o  output  1  empty indicator; high when occupancy == 0.

Function
REQ-011 SHALL keep write pointer, read pointer (range 0..DEP-1) and occupancy count (width clog2(DEP+1)).
REQ-012 Accepted write = wr_i && (!full || accepted read same edge); stores wdata at write pointer, pointer increments.
REQ-013 Accepted read = rd_i && !empty; on that edge rdata loads entry at read pointer, pointer increments; rdata visible 1 cycle after the sampling edge.
REQ-014 Pointers SHALL wrap from DEP-1 to 0.
REQ-015 Count: +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-016 Write while full with no accepted read SHALL be dropped; memory, pointers, count unchanged.
REQ-017 Read while empty SHALL be ignored; rdata holds its previous value.
REQ-018 Simultaneous rd_i and wr_i when empty: write accepted, read ignored (no write-to-read bypass); count becomes 1.
REQ-019 Simultaneous rd_i and wr_i when full: both accepted, count stays DEP, overflow_o stays high.
REQ-020 Simultaneous rd_i and wr_i with 0 < count < DEP: both accepted, count unchanged.
REQ-021 overflow_o and empty_o SHALL be decoded from registered count only (glitch-free, no combinational path from inputs).
REQ-022 rdata SHALL hold between accepted reads.
REQ-023 Data order SHALL be strictly first-in first-out.

Reset
REQ-024 rst low SHALL immediately, independent of clk, clear pointers and count, drive rdata = 0, empty_o = 1, overflow_o = 0.
REQ-025 Memory contents need not be cleared; stale entries SHALL never be readable after reset.
REQ-026 Reset asserted mid-operation SHALL discard all stored data; first accepted write after release lands in entry 0.
REQ-027 Requests on the first rising edge after rst deasserts SHALL be processed normally.

Verification
REQ-028 Reset: hold rst low, toggle wr_i/rd_i -> empty_o=1, overflow_o=0, rdata=0 throughout.
REQ-029 Concurrent from empty (DEP=4): wr_i=rd_i=1 for 10 cycles with data D0..D9 -> cycle 1 count=1, empty_o=0; each later edge rdata returns prior write (D0..D8); count stays 1.
REQ-030 Fill/overflow: from count 1, write-only 10 cycles -> 3 accepted, overflow_o=1 after count reaches 4, remaining 7 writes dropped, pointers unchanged.
REQ-031 Drain: read-only 10 cycles from full -> 4 values in write order (D9, then first three accepted fill values), empty_o=1 after 4th read, rdata holds last value for remaining 6 reads.
REQ-032 Wrap: with DEP=4, write 6 reading 1 per write after 3 -> pointers wrap, FIFO order preserved.
REQ-033 Mid-operation reset: assert rst with count=3 -> count=0, empty_o=1 immediately; next write/read returns new data, not stale.
